// File: rtl/mem_access_unit.sv
// Load/store initiator for a word-wide synchronous-read memory: byte/half stores via read-modify-write, load lane extract.
// Latency load 3, SW 2, SB/SH 4, error 1 cycle; req_ready only in IDLE, responses cannot be stalled.
module mem_access_unit #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int SET_WIDTH     = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [SET_WIDTH-1:0]     req_set,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wd,
    output logic                     resp_valid,
    output logic [DATA_WIDTH-1:0]    resp_rd,
    output logic                     resp_err,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic                     mem_re,
    output logic                     mem_we,
    output logic [DATA_WIDTH-1:0]    mem_wd,
    input  logic [DATA_WIDTH-1:0]    mem_rd
);

    localparam logic [SET_WIDTH-1:0] SET_B  = SET_WIDTH'(0);
    localparam logic [SET_WIDTH-1:0] SET_H  = SET_WIDTH'(1);
    localparam logic [SET_WIDTH-1:0] SET_W  = SET_WIDTH'(2);
    localparam logic [SET_WIDTH-1:0] SET_BU = SET_WIDTH'(4);
    localparam logic [SET_WIDTH-1:0] SET_HU = SET_WIDTH'(5);

    typedef enum logic [2:0] {
        IDLE,
        LD_RD,
        LD_WAIT,
        RMW_RD,
        RMW_WAIT,
        ST_WR,
        DONE
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    wd_q;
    logic [SET_WIDTH-1:0]     set_q;
    logic                     we_q;
    logic                     err_q;
    logic [DATA_WIDTH-1:0]    merged_q;
    logic [DATA_WIDTH-1:0]    load_q;

    logic                     req_err;
    logic                     accept;
    logic [7:0]               byte_sel;
    logic [15:0]              half_sel;
    logic [DATA_WIDTH-1:0]    load_ext;
    logic [DATA_WIDTH-1:0]    merged;
    logic [ADDRESS_WIDTH-1:0] word_addr;

    assign accept = (state == IDLE) && req_valid;

    // Unsigned sizes are load-only; reserved funct3 codes always fault.
    always_comb begin
        req_err = 1'b1;
        case (req_set)
            SET_B:   req_err = 1'b0;
            SET_H:   req_err = req_addr[0];
            SET_W:   req_err = |req_addr[1:0];
            SET_BU:  req_err = req_we;
            SET_HU:  req_err = req_we | req_addr[0];
            default: req_err = 1'b1;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_err)
                        state_nxt = DONE;
                    else if (!req_we)
                        state_nxt = LD_RD;
                    else if (req_set == SET_W)
                        state_nxt = ST_WR;
                    else
                        state_nxt = RMW_RD;
                end
            end
            LD_RD:    state_nxt = LD_WAIT;
            LD_WAIT:  state_nxt = DONE;
            RMW_RD:   state_nxt = RMW_WAIT;
            RMW_WAIT: state_nxt = ST_WR;
            ST_WR:    state_nxt = DONE;
            DONE:     state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        byte_sel = mem_rd[7:0];
        case (addr_q[1:0])
            2'b00: byte_sel = mem_rd[7:0];
            2'b01: byte_sel = mem_rd[15:8];
            2'b10: byte_sel = mem_rd[23:16];
            2'b11: byte_sel = mem_rd[31:24];
        endcase
        half_sel = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];

        load_ext = '0;
        case (set_q)
            SET_B:   load_ext = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            SET_H:   load_ext = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            SET_W:   load_ext = mem_rd;
            SET_BU:  load_ext = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            SET_HU:  load_ext = {{(DATA_WIDTH-16){1'b0}}, half_sel};
            default: load_ext = '0;
        endcase
    end

    always_comb begin
        merged = mem_rd;
        if (set_q == SET_B) begin
            case (addr_q[1:0])
                2'b00: merged[7:0]   = wd_q[7:0];
                2'b01: merged[15:8]  = wd_q[7:0];
                2'b10: merged[23:16] = wd_q[7:0];
                2'b11: merged[31:24] = wd_q[7:0];
            endcase
        end else if (addr_q[1]) begin
            merged[31:16] = wd_q[15:0];
        end else begin
            merged[15:0] = wd_q[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            addr_q   <= '0;
            wd_q     <= '0;
            set_q    <= '0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            merged_q <= '0;
            load_q   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr_q <= req_addr;
                wd_q   <= req_wd;
                set_q  <= req_set;
                we_q   <= req_we;
                err_q  <= req_err;
            end
            if (state == LD_WAIT)
                load_q <= load_ext;
            if (state == RMW_WAIT)
                merged_q <= merged;
        end
    end

    assign word_addr  = {addr_q[ADDRESS_WIDTH-1:2], 2'b00};
    assign req_ready  = (state == IDLE);
    assign mem_re     = (state == LD_RD) || (state == RMW_RD);
    assign mem_we     = (state == ST_WR);
    assign mem_addr   = (mem_re || mem_we) ? word_addr : '0;
    assign mem_wd     = mem_we ? ((set_q == SET_W) ? wd_q : merged_q) : '0;
    assign resp_valid = (state == DONE);
    assign resp_err   = (state == DONE) && err_q;
    // Last load result stays visible between responses; stores and faults answer zero.
    assign resp_rd    = ((state == DONE) && (we_q || err_q)) ? '0 : load_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus random requests against a word-array reference model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, req_valid, req_ready, req_we;
    logic [2:0]  req_set;
    logic [31:0] req_addr, req_wd;
    logic        resp_valid, resp_err, mem_re, mem_we;
    logic [31:0] resp_rd, mem_addr, mem_wd, mem_rd;

    logic [31:0] mem     [0:63];
    logic [31:0] ref_mem [0:63];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_idx;
    logic [31:0] pl_dat;

    int checks = 0;
    int fails  = 0;

    int          last_n;
    logic [31:0] last_rd;
    logic        last_err;
    int          last_re_cyc, last_we_cyc, last_re_cnt;
    logic [31:0] last_wd;

    mem_access_unit dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_set(req_set), .req_addr(req_addr), .req_wd(req_wd),
        .resp_valid(resp_valid), .resp_rd(resp_rd), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always @(posedge clk) begin
        if (pl_en) mem[pl_idx] <= pl_dat;
        if (mem_we) mem[mem_addr[7:2]] <= mem_wd;
        if (mem_re) mem_rd <= mem[mem_addr[7:2]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] dat);
        @(negedge clk);
        pl_en  = 1'b1;
        pl_idx = 6'(idx);
        pl_dat = dat;
        @(negedge clk);
        pl_en  = 1'b0;
        ref_mem[idx] = dat;
    endtask

    task automatic run_req(input logic we, input logic [2:0] set, input logic [31:0] addr,
                           input logic [31:0] wd);
        logic        err;
        int          exp_n, idx, sh, hs;
        logic [31:0] w, b, h, exp_rd, exp_word;
        int          re_cnt = 0, we_cnt = 0, re_cyc = 0, we_cyc = 0, got_n = 0;
        logic [31:0] re_addr = 0, we_addr = 0, got_wd = 0, got_rd = 0;
        logic        got_err = 1'b0, both = 1'b0;

        idx = int'(addr[7:2]);
        sh  = int'(addr[1:0]) * 8;
        hs  = int'(addr[1]) * 16;
        w   = ref_mem[idx];
        b   = (w >> sh) & 32'hFF;
        h   = (w >> hs) & 32'hFFFF;
        err = (set == 3'd3) || (set == 3'd6) || (set == 3'd7) || (we && set >= 3'd4) ||
              ((set == 3'd1 || set == 3'd5) && addr[0]) || (set == 3'd2 && addr[1:0] != 2'd0);
        exp_n    = err ? 1 : (!we ? 3 : (set == 3'd2 ? 2 : 4));
        exp_rd   = 0;
        exp_word = w;
        if (!err && !we) begin
            case (set)
                3'd0:    exp_rd = (b >= 128) ? b - 32'd256 : b;
                3'd1:    exp_rd = (h >= 32768) ? h - 32'd65536 : h;
                3'd2:    exp_rd = w;
                3'd4:    exp_rd = b;
                default: exp_rd = h;
            endcase
        end
        if (!err && we) begin
            if (set == 3'd0)
                exp_word = (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
            else if (set == 3'd1)
                exp_word = (w & ~(32'hFFFF << hs)) | ((wd & 32'hFFFF) << hs);
            else
                exp_word = wd;
        end

        @(negedge clk);
        check("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_set   = set;
        req_addr  = addr;
        req_wd    = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wd    = $urandom;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (mem_re) begin
                re_cnt++;
                if (re_cyc == 0) begin re_cyc = n; re_addr = mem_addr; end
            end
            if (mem_we) begin
                we_cnt++;
                if (we_cyc == 0) begin we_cyc = n; we_addr = mem_addr; got_wd = mem_wd; end
            end
            if (mem_re && mem_we) both = 1'b1;
            if (resp_valid) begin
                got_n   = n;
                got_rd  = resp_rd;
                got_err = resp_err;
                break;
            end
        end

        check("latency", got_n, exp_n);
        check("resp_err", {31'd0, got_err}, {31'd0, err});
        check("resp_rd", got_rd, exp_rd);
        check("mem_re_count", re_cnt, (err || (we && set == 3'd2)) ? 0 : 1);
        check("mem_we_count", we_cnt, (err || !we) ? 0 : 1);
        check("strobes_exclusive", {31'd0, both}, 32'd0);
        if (re_cnt != 0) begin
            check("mem_re_cycle", re_cyc, 1);
            check("mem_re_addr", re_addr, {addr[31:2], 2'b00});
        end
        if (we_cnt != 0) begin
            check("mem_we_cycle", we_cyc, exp_n - 1);
            check("mem_we_addr", we_addr, {addr[31:2], 2'b00});
            check("mem_wd", got_wd, exp_word);
        end
        if (!err && we) ref_mem[idx] = exp_word;

        last_n      = got_n;
        last_rd     = got_rd;
        last_err    = got_err;
        last_re_cyc = re_cyc;
        last_re_cnt = re_cnt;
        last_we_cyc = we_cyc;
        last_wd     = got_wd;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw_we, saw_resp;
        rst_n     = 1'b0;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_set   = 3'd2;
        req_addr  = 32'h40;
        req_wd    = 32'h0;

        for (int i = 0; i < 64; i++) preload(i, $urandom);
        preload(16, 32'h8081_7F01);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_re", {31'd0, mem_re}, 32'd0);
        check("rst_resp_rd", resp_rd, 32'd0);
        req_valid = 1'b0;
        rst_n     = 1'b1;
        @(negedge clk);
        check("post_rst_no_accept", {31'd0, req_ready}, 32'd1);

        run_req(1'b0, 3'd0, 32'h43, 32'h0);
        check("lb_0x43", last_rd, 32'hFFFF_FF80);
        check("lb_latency", last_n, 3);
        run_req(1'b0, 3'd4, 32'h43, 32'h0);
        check("lbu_0x43", last_rd, 32'h0000_0080);
        run_req(1'b0, 3'd1, 32'h42, 32'h0);
        check("lh_0x42", last_rd, 32'hFFFF_8081);
        run_req(1'b0, 3'd2, 32'h40, 32'h0);
        check("lw_0x40", last_rd, 32'h8081_7F01);

        preload(16, 32'h1122_3344);
        run_req(1'b1, 3'd0, 32'h41, 32'hDEAD_BEAA);
        check("sb_re_cycle", last_re_cyc, 1);
        check("sb_we_cycle", last_we_cyc, 3);
        check("sb_mem_wd", last_wd, 32'h1122_AA44);
        check("sb_latency", last_n, 4);
        check("sb_err", {31'd0, last_err}, 32'd0);

        run_req(1'b1, 3'd2, 32'h44, 32'hCAFE_F00D);
        check("sw_we_cycle", last_we_cyc, 1);
        check("sw_no_re", last_re_cnt, 0);
        check("sw_latency", last_n, 2);
        check("sw_mem_wd", last_wd, 32'hCAFE_F00D);

        run_req(1'b0, 3'd2, 32'h42, 32'h0);
        check("err_lw_misaligned", {31'd0, last_err}, 32'd1);
        run_req(1'b1, 3'd1, 32'h45, 32'h1234);
        check("err_sh_misaligned", {31'd0, last_err}, 32'd1);
        run_req(1'b0, 3'd3, 32'h40, 32'h0);
        check("err_load_set3", {31'd0, last_err}, 32'd1);
        run_req(1'b1, 3'd4, 32'h40, 32'h55);
        check("err_store_set4", {31'd0, last_err}, 32'd1);
        check("err_latency", last_n, 1);

        // Abort a halfword store while its read data is being merged.
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_set   = 3'd1;
        req_addr  = 32'h46;
        req_wd    = 32'hBEEF_5A5A;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("abort_rmw_rd", {31'd0, mem_re}, 32'd1);
        @(negedge clk);
        rst_n    = 1'b0;
        saw_we   = 1'b0;
        saw_resp = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (mem_we) saw_we = 1'b1;
            if (resp_valid) saw_resp = 1'b1;
        end
        rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            if (mem_we) saw_we = 1'b1;
            if (resp_valid) saw_resp = 1'b1;
        end
        check("abort_no_we", {31'd0, saw_we}, 32'd0);
        check("abort_no_resp", {31'd0, saw_resp}, 32'd0);
        check("abort_ready", {31'd0, req_ready}, 32'd1);
        check("abort_mem_unchanged", mem[17], ref_mem[17]);

        for (int i = 0; i < 300; i++)
            run_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    32'($urandom_range(0, 255)), $urandom);

        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            check("final_mem", mem[i], ref_mem[i]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
